// File: rtl/rvvi_arb_pkg.sv
// Shared constants and the round-robin pick helper for the RVVI retire arbiter.
package rvvi_arb_pkg;

  localparam int ORDER_W  = 64;
  localparam int MODE_W   = 2;
  localparam int MAX_HART = 32;
  localparam int IDX_W    = 5;

  // Returns a one-hot grant for the first requester after 'last', wrapping at n.
  // Requests above n-1 are ignored.
  function automatic logic [MAX_HART-1:0] rr_pick(input logic [MAX_HART-1:0] req,
                                                  input logic [IDX_W-1:0]    last,
                                                  input int                  n);
    logic [MAX_HART-1:0] grant;
    logic [IDX_W-1:0]    idx;
    grant = '0;
    idx   = '0;
    for (int k = 1; k <= MAX_HART; k++) begin
      if (k <= n) begin
        idx = IDX_W'((int'(last) + k) % n);
        if ((grant == '0) && req[idx]) begin
          grant[idx] = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rvvi_retire_fifo.sv
// Per-hart retirement FIFO: registered count, no pass-through from push to pop.
module rvvi_retire_fifo
  import rvvi_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  output logic                       full,
  input  logic                       pop,
  output logic                       empty,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];
  assign count   = cnt;

  // Storage array; contents are don't-care until written, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/rvvi_retire_arbiter.sv
// Merges per-hart retire events into one ordered RVVI trace slot.
// Optional build macro RVVI_TRAP_PRIORITY_EN: trap heads win arbitration over
// non-trap heads (still round-robin among themselves, sharing rr_last).
module rvvi_retire_arbiter
  import rvvi_arb_pkg::*;
#(
  parameter int NHART = 2,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NHART-1:0]                       in_valid,
  output logic [NHART-1:0]                       in_ready,
  input  logic [NHART*XLEN-1:0]                  in_pc,
  input  logic [NHART*ILEN-1:0]                  in_insn,
  input  logic [NHART-1:0]                       in_trap,
  input  logic [NHART*MODE_W-1:0]                in_mode,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [((NHART > 1) ? $clog2(NHART) : 1)-1:0] out_hart,
  output logic [ORDER_W-1:0]                     out_order,
  output logic [XLEN-1:0]                        out_pc,
  output logic [ILEN-1:0]                        out_insn,
  output logic                                   out_trap,
  output logic [MODE_W-1:0]                      out_mode
);

  localparam int HW = (NHART > 1) ? $clog2(NHART) : 1;
  localparam int EW = XLEN + ILEN + 1 + MODE_W;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NHART-1:0]    push;
  logic [NHART-1:0]    pop;
  logic [NHART-1:0]    full;
  logic [NHART-1:0]    empty;
  logic [EW-1:0]       head  [NHART];
  logic [CW-1:0]       count [NHART];

  logic [HW-1:0]       rr_last;
  logic [ORDER_W-1:0]  order_cnt;
  logic [MAX_HART-1:0] req_w;
  logic [MAX_HART-1:0] grant_w;
  logic [HW-1:0]       grant_idx;
  logic                grant_any;
  logic                load;
  logic [EW-1:0]       sel;

  for (genvar h = 0; h < NHART; h++) begin : g_hart
    assign in_ready[h] = (count[h] != CW'(DEPTH));
    assign push[h]     = in_valid[h] & ~full[h];
    assign pop[h]      = load & grant_w[h] & ~empty[h];

    rvvi_retire_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[h]),
      .wdata ({in_pc[h*XLEN +: XLEN], in_insn[h*ILEN +: ILEN],
               in_trap[h], in_mode[h*MODE_W +: MODE_W]}),
      .full  (full[h]),
      .pop   (pop[h]),
      .empty (empty[h]),
      .rdata (head[h]),
      .count (count[h])
    );
  end

  // Round-robin grant over non-empty heads, optionally favouring trap heads.
  always_comb begin
    req_w              = '0;
    req_w[NHART-1:0]   = ~empty;
`ifdef RVVI_TRAP_PRIORITY_EN
    begin
      logic [MAX_HART-1:0] trap_req;
      trap_req = '0;
      for (int i = 0; i < NHART; i++) begin
        trap_req[i] = ~empty[i] & head[i][MODE_W];
      end
      if (trap_req != '0) begin
        grant_w = rr_pick(trap_req, IDX_W'(rr_last), NHART);
      end else begin
        grant_w = rr_pick(req_w, IDX_W'(rr_last), NHART);
      end
    end
`else
    grant_w = rr_pick(req_w, IDX_W'(rr_last), NHART);
`endif
  end

  // Convert the one-hot grant into a hart index for the output mux.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NHART; i++) begin
      if (grant_w[i]) grant_idx = HW'(i);
    end
  end

  assign grant_any = |grant_w;
  assign load      = grant_any & (~out_valid | out_ready);
  assign sel       = head[grant_idx];

  // Output slot, order stamping and round-robin pointer update on each load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_hart  <= '0;
      out_order <= '0;
      out_pc    <= '0;
      out_insn  <= '0;
      out_trap  <= 1'b0;
      out_mode  <= '0;
      order_cnt <= '0;
      rr_last   <= HW'(NHART - 1);
    end else if (load) begin
      out_valid <= 1'b1;
      out_hart  <= grant_idx;
      out_order <= order_cnt + 1'b1;
      out_pc    <= sel[EW-1 -: XLEN];
      out_insn  <= sel[ILEN+MODE_W : MODE_W+1];
      out_trap  <= sel[MODE_W];
      out_mode  <= sel[MODE_W-1:0];
      order_cnt <= order_cnt + 1'b1;
      rr_last   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
